// File: rtl/sbinit_sb_tx_serializer.sv
// SBINIT sideband TX serializer: arbitrates wrapper messages, builds a 64-bit packet,
// shifts it LSB-first, then holds the inter-packet gap. Define SB_CP_PARITY_EN for bit-62 parity.
module sbinit_sb_tx_serializer #(
  parameter int SB_MSG_WIDTH = 4,
  parameter int PKT_WIDTH    = 64,
  parameter int GAP_CYCLES   = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_tx_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_tx_msg,
  input  logic                    i_rx_valid,
  input  logic [SB_MSG_WIDTH-1:0] i_rx_msg,
  output logic                    o_sb_busy,
  output logic                    o_falling_edge_busy,
  output logic                    o_tx_ack,
  output logic                    o_rx_ack,
  output logic                    o_TXDATASB,
  output logic                    o_TXCKSB_en,
  output logic                    o_unknown_msg
);

  localparam int IDX_W = $clog2(PKT_WIDTH);

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  state_t                  state, state_n;
  logic [6:0]              cnt, cnt_n;
  logic [PKT_WIDTH-1:0]    pkt, pkt_n;
  logic                    served_rx, served_rx_n;
  logic                    accept, sel_rx, sel_supported;
  logic [SB_MSG_WIDTH-1:0] sel_msg;
  logic [7:0]              sel_code, sel_sub;
  logic                    busy_n, feb_n, tx_ack_n, rx_ack_n, data_n, en_n, unknown_n;

  function automatic logic [PKT_WIDTH-1:0] build_packet(input logic [7:0] code,
                                                        input logic [7:0] sub);
    logic [PKT_WIDTH-1:0] p;
    p        = '0;
    p[4:0]   = 5'b10010;
    p[21:14] = code;
    p[29:27] = 3'b010;
    p[39:32] = sub;
    p[58:56] = 3'b110;
`ifdef SB_CP_PARITY_EN
    p[62]    = ^p[61:0];
`endif
    return p;
  endfunction

  // RX has priority; the ack cycle blocks acceptance because the served valid is still stale-high.
  always_comb begin
    sel_rx        = i_rx_valid;
    sel_msg       = i_rx_valid ? i_rx_msg : i_tx_msg;
    accept        = (state == IDLE) && !(o_tx_ack || o_rx_ack) && (i_rx_valid || i_tx_valid);
    sel_supported = 1'b1;
    sel_code      = 8'h00;
    sel_sub       = 8'h00;
    case (sel_msg)
      SB_MSG_WIDTH'(1): begin sel_code = 8'h95; sel_sub = 8'h01; end
      SB_MSG_WIDTH'(2): begin sel_code = 8'h9A; sel_sub = 8'h01; end
      default:          sel_supported = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state               <= IDLE;
      cnt                 <= '0;
      pkt                 <= '0;
      served_rx           <= 1'b0;
      o_sb_busy           <= 1'b0;
      o_falling_edge_busy <= 1'b0;
      o_tx_ack            <= 1'b0;
      o_rx_ack            <= 1'b0;
      o_TXDATASB          <= 1'b0;
      o_TXCKSB_en         <= 1'b0;
      o_unknown_msg       <= 1'b0;
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      pkt                 <= pkt_n;
      served_rx           <= served_rx_n;
      o_sb_busy           <= busy_n;
      o_falling_edge_busy <= feb_n;
      o_tx_ack            <= tx_ack_n;
      o_rx_ack            <= rx_ack_n;
      o_TXDATASB          <= data_n;
      o_TXCKSB_en         <= en_n;
      o_unknown_msg       <= unknown_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    pkt_n       = pkt;
    served_rx_n = served_rx;
    case (state)
      IDLE: begin
        if (accept && sel_supported) begin
          state_n     = SHIFT;
          cnt_n       = '0;
          pkt_n       = build_packet(sel_code, sel_sub);
          served_rx_n = sel_rx;
        end
      end
      SHIFT: begin
        if (cnt == 7'(PKT_WIDTH - 1)) begin
          state_n = GAP;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 7'd1;
        end
      end
      GAP: begin
        if (cnt == 7'(GAP_CYCLES - 1)) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + 7'd1;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // Outputs are computed from next-state values so every output is a flop.
  always_comb begin
    en_n      = (state_n == SHIFT);
    busy_n    = (state_n != IDLE);
    data_n    = en_n && pkt_n[cnt_n[IDX_W-1:0]];
    feb_n     = (state == GAP) && (state_n == IDLE);
    rx_ack_n  = (feb_n && served_rx)  || (accept && !sel_supported && sel_rx);
    tx_ack_n  = (feb_n && !served_rx) || (accept && !sel_supported && !sel_rx);
    unknown_n = o_unknown_msg || (accept && !sel_supported);
  end

endmodule

// File: tb/tb_sbinit_sb_tx_serializer.sv
// Directed self-checking bench for sbinit_sb_tx_serializer; expected packets are hand-computed.
module tb_sbinit_sb_tx_serializer;

  logic       clk;
  logic       rst;
  logic       txValid, rxValid;
  logic [3:0] txMsg, rxMsg;
  logic       busy, feb, txAck, rxAck, txData, txClkEn, unknownMsg;

  int checkCount = 0;
  int failCount  = 0;
  int dualAck    = 0;
  logic expUnknown;

  // Done req (95/01) and done resp (9A/01) with opcode, srcid and dstid fields filled in.
  localparam logic [63:0] PKT_REQ_RAW  = 64'h0600_0001_1025_4012;
  localparam logic [63:0] PKT_RESP_RAW = 64'h0600_0001_1026_8012;

  sbinit_sb_tx_serializer dut (
    .i_clk               (clk),
    .i_rst               (rst),
    .i_tx_valid          (txValid),
    .i_tx_msg            (txMsg),
    .i_rx_valid          (rxValid),
    .i_rx_msg            (rxMsg),
    .o_sb_busy           (busy),
    .o_falling_edge_busy (feb),
    .o_tx_ack            (txAck),
    .o_rx_ack            (rxAck),
    .o_TXDATASB          (txData),
    .o_TXCKSB_en         (txClkEn),
    .o_unknown_msg       (unknownMsg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) if (txAck && rxAck) dualAck++;

  function automatic logic [63:0] withParity(input logic [63:0] p);
    logic [63:0] q;
    q = p;
`ifdef SB_CP_PARITY_EN
    q[62] = ^q[61:0];
`endif
    return q;
  endfunction

  function automatic logic [6:0] outVec();
    return {busy, feb, txAck, rxAck, txData, txClkEn, unknownMsg};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Entered at T+1; returns at T+97 after checking the release cycle.
  task automatic observePacket(input string tag, input logic [63:0] expPkt, input logic expRx);
    logic [63:0] got;
    int shiftGood, gapGood, busyCnt;
    got = '0; shiftGood = 0; gapGood = 0; busyCnt = 0;
    for (int k = 0; k < 64; k++) begin
      got[k] = txData;
      if (busy && txClkEn && !feb && !txAck && !rxAck) shiftGood++;
      if (busy) busyCnt++;
      step();
    end
    for (int k = 0; k < 32; k++) begin
      if (busy && !txClkEn && !txData && !feb && !txAck && !rxAck) gapGood++;
      if (busy) busyCnt++;
      step();
    end
    checkOutput({tag, " packet"}, got, expPkt);
    checkOutput({tag, " shift cycles"}, 64'(shiftGood), 64'd64);
    checkOutput({tag, " gap cycles"}, 64'(gapGood), 64'd32);
    checkOutput({tag, " busy cycles"}, 64'(busyCnt), 64'd96);
    checkOutput({tag, " release"}, 64'(outVec()),
                64'({1'b0, 1'b1, ~expRx, expRx, 1'b0, 1'b0, expUnknown}));
  endtask

  task automatic applyStimulus();
    int quiet;
    rst = 1'b1; txValid = 1'b0; rxValid = 1'b0; txMsg = '0; rxMsg = '0; expUnknown = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset outputs", 64'(outVec()), 64'd0);
    rst = 1'b0;
    step();
    checkOutput("idle after reset", 64'(outVec()), 64'd0);

    // RX done resp, valid held through the ack cycle
    rxMsg = 4'd2; rxValid = 1'b1;
    step();
    observePacket("rx resp", withParity(PKT_RESP_RAW), 1'b1);
    step();
    rxValid = 1'b0;
    quiet = 0;
    for (int k = 0; k < 6; k++) begin
      if (outVec() == 7'd0) quiet++;
      step();
    end
    checkOutput("no repeat after stale valid", 64'(quiet), 64'd6);

    // TX done req
    txMsg = 4'd1; txValid = 1'b1;
    step();
    observePacket("tx req", withParity(PKT_REQ_RAW), 1'b0);
    step();
    txValid = 1'b0;
    step();

    // Both valid: RX first, TX after the gap
    txMsg = 4'd1; rxMsg = 4'd2; txValid = 1'b1; rxValid = 1'b1;
    step();
    observePacket("both rx first", withParity(PKT_RESP_RAW), 1'b1);
    step();
    rxValid = 1'b0;
    step();
    observePacket("both tx second", withParity(PKT_REQ_RAW), 1'b0);
    step();
    txValid = 1'b0;
    step();

    // Unsupported codes
    txMsg = 4'd5; txValid = 1'b1;
    step();
    checkOutput("tx code 5 ack", 64'(outVec()), 64'(7'b0010001));
    step();
    txValid = 1'b0;
    expUnknown = 1'b1;
    checkOutput("tx code 5 single ack", 64'(outVec()), 64'(7'b0000001));
    rxMsg = 4'd0; rxValid = 1'b1;
    step();
    checkOutput("rx code 0 ack", 64'(outVec()), 64'(7'b0001001));
    step();
    rxValid = 1'b0;
    checkOutput("unknown sticky", 64'(outVec()), 64'(7'b0000001));

    // Reset while bit 20 is on the lane
    txMsg = 4'd1; txValid = 1'b1;
    step();
    repeat (20) step();
    checkOutput("mid shift bit20", 64'(outVec()), 64'(7'b1000011));
    #2;
    rst = 1'b1;
    txValid = 1'b0;
    #1;
    checkOutput("async reset", 64'(outVec()), 64'd0);
    expUnknown = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    quiet = 0;
    for (int k = 0; k < 8; k++) begin
      if (outVec() == 7'd0) quiet++;
      step();
    end
    checkOutput("idle after mid reset", 64'(quiet), 64'd8);
    checkOutput("never two acks", 64'(dualAck), 64'd0);
  endtask

  initial begin
    applyStimulus();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/sbinit_sb_tx_serializer.md
# sbinit_sb_tx_serializer

- Downstream stage of the SBINIT TX and RX message wrappers.
- Accepts a 4-bit encoded SBINIT message from either wrapper, arbitrates between them, and builds a 64-bit sideband packet.
- Shifts the packet out LSB-first on the sideband data lane, then enforces the 32-cycle inter-packet gap.
- Produces the busy and falling-edge-busy indications the wrappers use to hold and release their valids.

## Interface

Parameters:
- SB_MSG_WIDTH, 4, width of encoded message code.
- PKT_WIDTH, 64, sideband packet length in bits.
- GAP_CYCLES, 32, idle cycles after each packet.

Ports:
- i_clk  input  1  sideband clock.
- i_rst  input  1  reset; asynchronous, active-high.
- i_tx_valid  input  1  TX wrapper has a message.
- i_tx_msg  input  SB_MSG_WIDTH  TX wrapper encoded message.
- i_rx_valid  input  1  RX wrapper has a message.
- i_rx_msg  input  SB_MSG_WIDTH  RX wrapper encoded message.
- o_sb_busy  output  1  packet or gap in progress.
- o_falling_edge_busy  output  1  one-cycle pulse when busy drops.
- o_tx_ack  output  1  one-cycle pulse: TX message consumed.
- o_rx_ack  output  1  one-cycle pulse: RX message consumed.
- o_TXDATASB  output  1  serial sideband data.
- o_TXCKSB_en  output  1  sideband clock gate enable; high only while bits shift.
- o_unknown_msg  output  1  sticky; an unsupported code was received.

## Operation

Message map. Any other code, including 0, is unsupported.
- 1 = SBINIT done req: MsgCode 8'h95, MsgSubcode 8'h01.
- 2 = SBINIT done resp: MsgCode 8'h9A, MsgSubcode 8'h01.

Packet bits; every bit not listed is 0.
- [4:0] opcode 5'b10010.
- [21:14] MsgCode.
- [29:27] srcid 3'b010.
- [39:32] MsgSubcode.
- [58:56] dstid 3'b110.
- [62] CP.
- [63] DP = 0.

FSM states: IDLE, SHIFT, GAP.
- IDLE: accepts when either valid is high and no ack pulse is being driven this cycle.
  - Both valid: RX wins. TX stays pending and is served after the next gap.
  - Selected msg is sampled into the packet register at acceptance; source valid must stay high until its ack.
  - Supported code: go to SHIFT.
  - Unsupported code: stay in IDLE, pulse that source's ack next cycle, set o_unknown_msg. No busy, no falling-edge pulse.
- SHIFT: 7-bit counter 0..63 drives bit[count] onto o_TXDATASB; after bit 63 go to GAP.
- GAP: counter 0..GAP_CYCLES-1, then IDLE. At entry to IDLE, pulse o_falling_edge_busy and the served source's ack for one cycle.

Reset: asynchronous, mid-operation included. State returns to IDLE and counters are cleared. Every output resets to 0. The packet is abandoned with no ack and no falling-edge pulse.

## Timing

Valid sampled high in IDLE at cycle T:
- T+1..T+64: o_sb_busy=1, o_TXCKSB_en=1, o_TXDATASB = bit0..bit63 (all registered outputs).
- T+65..T+96: o_sb_busy=1, o_TXCKSB_en=0, o_TXDATASB=0.
- T+97: o_sb_busy=0, o_falling_edge_busy=1, served ack=1.
  - IDLE must not accept in this cycle; the stale valid is still high.
  - Earliest next acceptance is T+98, next first bit at T+99.

Other timing rules:
- Unsupported code at T: ack at T+1, next acceptance at T+2.
- A valid rising while busy waits; it is never dropped.
- o_TXDATASB is 0 whenever o_TXCKSB_en=0.

## Configuration

Macro SB_CP_PARITY_EN.
- Defined: bit 62 = XOR of packet bits [61:0], even control parity.
- Undefined: bit 62 = 0. No parity logic is generated.

## Test plan

- Reset mid-SHIFT: assert i_rst at bit 20 -> all outputs 0 immediately, no ack; after release, idle until the next valid.
- RX msg 2 valid at T -> bits [21:14]=8'h9A, [39:32]=8'h01, [4:0]=5'b10010; o_rx_ack and o_falling_edge_busy at T+97; o_sb_busy high exactly 96 cycles.
- TX msg 1 with SB_CP_PARITY_EN defined -> MsgCode 8'h95, bit62 = XOR[61:0]. Same test with the macro undefined -> bit62=0.
- Both valid at T (TX=1, RX=2) -> RX packet first, o_rx_ack at T+97; TX accepted at T+98, o_tx_ack at T+195; never two acks in one cycle.
- TX msg 5 -> no busy, o_tx_ack at T+1, o_unknown_msg=1 and stays set until reset.
- Valid held one cycle past ack -> no second packet; o_TXCKSB_en stays 0.
